// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Turns the UART byte stream into imem writes. A frame is a little-endian
// word count, that many instruction words, then a 32-bit sum of those words.
// The core is held in reset until a complete image has been written and its
// checksum has matched.
//
// state    | meaning
// ---------+------------------------------------------------------------
// GET_LEN  | collecting the 4-byte word count N
// GET_DATA | collecting data words; each completed word is written to imem
// GET_SUM  | collecting the 4-byte checksum
// DONE     | image verified, core released, further bytes ignored
// ERROR    | bad length or checksum, core held, only reset leaves
module imem_boot_loader #(
    parameter int          MAX_WORDS      = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        InstWrite,
    output logic [31:0] WriteInst,
    output logic [31:0] WriteAdress,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [12:0] words_loaded
);

    // The idle timer is a down-counter reloaded on every accepted byte; the
    // abort fires when it is already at zero on an idle cycle.
    localparam int                TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       MAX_W32  = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        GET_LEN  = 3'd0,
        GET_DATA = 3'd1,
        GET_SUM  = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       sum_q, sum_d;
    logic              inst_write_q, inst_write_d;
    logic [31:0]       write_inst_q, write_inst_d;
    logic [31:0]       write_addr_q, write_addr_d;
    logic              core_reset_q, core_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [12:0]       words_q, words_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              active_q, active_d;

    logic              in_frame;
    logic              last_byte;
    logic [31:0]       word_w;

    // Frame parser, word assembly, imem write generation and idle timeout.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        len_d        = len_q;
        sum_d        = sum_q;
        inst_write_d = 1'b0;
        write_inst_d = write_inst_q;
        write_addr_d = write_addr_q;
        core_reset_d = core_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        words_d      = words_q;
        timer_d      = timer_q;
        active_d     = active_q;

        in_frame  = (state_q == GET_LEN) || (state_q == GET_DATA) || (state_q == GET_SUM);
        last_byte = (byte_cnt_q == 2'd3);
        // Bytes arrive LSB first, so the newest byte lands in the top lane.
        word_w    = {rx_data, shift_q};

        if (in_frame && rx_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = word_w[31:8];
            timer_d    = TMR_LOAD;
            active_d   = 1'b1;

            if (last_byte) begin
                case (state_q)
                    GET_LEN: begin
                        len_d = word_w;
                        if ((word_w == 32'd0) || (word_w > MAX_W32)) begin
                            state_d      = ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            state_d = GET_DATA;
                        end
                    end
                    GET_DATA: begin
                        inst_write_d = 1'b1;
                        write_inst_d = word_w;
                        write_addr_d = BASE_ADDR + {17'd0, words_q, 2'b00};
                        words_d      = words_q + 13'd1;
                        sum_d        = sum_q + word_w;
                        if (({19'd0, words_q} + 32'd1) == len_q) begin
                            state_d = GET_SUM;
                        end
                    end
                    GET_SUM: begin
                        if (word_w == sum_q) begin
                            state_d      = DONE;
                            load_done_d  = 1'b1;
                            core_reset_d = 1'b0;
                        end else begin
                            state_d      = ERROR;
                            load_error_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else if (in_frame && active_q) begin
            // Abandon a stalled frame; words already written stay in imem.
            if (timer_q == '0) begin
                state_d    = GET_LEN;
                byte_cnt_d = 2'd0;
                words_d    = 13'd0;
                sum_d      = 32'd0;
                active_d   = 1'b0;
            end else begin
                timer_d = timer_q - TMR_W'(1);
            end
        end
    end

    // State and output registers; reset takes priority over any incoming byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= GET_LEN;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            len_q        <= 32'd0;
            sum_q        <= 32'd0;
            inst_write_q <= 1'b0;
            write_inst_q <= 32'd0;
            write_addr_q <= BASE_ADDR;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            words_q      <= 13'd0;
            timer_q      <= TMR_LOAD;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            inst_write_q <= inst_write_d;
            write_inst_q <= write_inst_d;
            write_addr_q <= write_addr_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            words_q      <= words_d;
            timer_q      <= timer_d;
            active_q     <= active_d;
        end
    end

    assign InstWrite    = inst_write_q;
    assign WriteInst    = write_inst_q;
    assign WriteAdress  = write_addr_q;
    assign core_reset   = core_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule
